// File: rtl/cv32e40p_instr_l0_buffer_pkg.sv
// Shared types and constants for the single-line L0 instruction buffer.
package cv32e40p_pkg;

  localparam int unsigned L0_LINE_WORDS_DEFAULT = 4;

  typedef enum logic [1:0] {
    L0_IDLE,
    L0_FILL,
    L0_DONE
  } l0_state_e;

  // Response payload returned to the prefetch buffer
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } l0_rsp_t;

endpackage

// File: rtl/cv32e40p_l0_fill_ctrl.sv
// Line-fill sequencer: grant/response counters and the OBI master request toward memory.
module cv32e40p_l0_fill_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int unsigned LINE_WORDS = L0_LINE_WORDS_DEFAULT,
  localparam int unsigned IDX = $clog2(LINE_WORDS),
  localparam int unsigned TAG_W = 30 - IDX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             fill_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             instr_gnt_i,
  input  logic             instr_rvalid_i,
  output logic             instr_req_o,
  output logic [31:0]      instr_addr_o,
  output logic [IDX-1:0]   rsp_idx_o,
  output logic             rsp_last_o
);

  localparam logic [IDX:0] CNT_FULL = (IDX + 1)'(LINE_WORDS);
  localparam logic [IDX:0] CNT_LAST = (IDX + 1)'(LINE_WORDS - 1);

  logic [IDX:0] gnt_cnt_q;
  logic [IDX:0] rsp_cnt_q;

  // Request stays up with a stable address until memory grants it
  assign instr_req_o  = fill_i & (gnt_cnt_q < CNT_FULL);
  assign instr_addr_o = instr_req_o ? {tag_i, gnt_cnt_q[IDX-1:0], 2'b00} : 32'h0;
  assign rsp_idx_o    = rsp_cnt_q[IDX-1:0];
  assign rsp_last_o   = fill_i & instr_rvalid_i & (rsp_cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt_q <= '0;
      rsp_cnt_q <= '0;
    end else if (start_i) begin
      gnt_cnt_q <= '0;
      rsp_cnt_q <= '0;
    end else if (fill_i) begin
      if (instr_req_o && instr_gnt_i) begin
        gnt_cnt_q <= gnt_cnt_q + (IDX + 1)'(1);
      end
      if (instr_rvalid_i) begin
        rsp_cnt_q <= rsp_cnt_q + (IDX + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/cv32e40p_instr_l0_buffer.sv
// Single-line L0 instruction buffer between the prefetch OBI port and instruction memory.
// Optional hit/miss performance counters are enabled with CV32E40P_L0_PERF_EN.
module cv32e40p_instr_l0_buffer
  import cv32e40p_pkg::*;
#(
  parameter int unsigned LINE_WORDS = L0_LINE_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        core_instr_req_i,
  output logic        core_instr_gnt_o,
  input  logic [31:0] core_instr_addr_i,
  output logic        core_instr_rvalid_o,
  output logic [31:0] core_instr_rdata_o,
  output logic        core_instr_err_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
);

  localparam int unsigned IDX   = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W = 30 - IDX;

  l0_state_e        state_q, state_d;
  logic             line_valid_q;
  logic [TAG_W-1:0] tag_q;
  logic [IDX-1:0]   crit_q;
  logic             err_seen_q;
  logic             flush_seen_q;
  logic [31:0]      line_q [LINE_WORDS];
  l0_rsp_t          rsp_q;
  logic             rvalid_q;

  logic [TAG_W-1:0] req_tag;
  logic [IDX-1:0]   req_idx;
  logic             hit;
  logic             hit_gnt;
  logic             miss_gnt;
  logic             fill;
  logic             rsp_we;
  logic [IDX-1:0]   rsp_idx;
  logic             rsp_last;
  logic             unused_addr;

  assign req_tag     = core_instr_addr_i[31:IDX+2];
  assign req_idx     = core_instr_addr_i[IDX+1:2];
  assign unused_addr = ^core_instr_addr_i[1:0];

  // A same-cycle flush must not be served from the stale line
  assign hit              = line_valid_q & (tag_q == req_tag) & ~flush_i;
  assign core_instr_gnt_o = core_instr_req_i & (state_q == L0_IDLE);
  assign hit_gnt          = core_instr_gnt_o & hit;
  assign miss_gnt         = core_instr_gnt_o & ~hit;
  assign fill             = (state_q == L0_FILL);
  assign rsp_we           = fill & instr_rvalid_i;

  cv32e40p_l0_fill_ctrl #(
    .LINE_WORDS (LINE_WORDS)
  ) u_fill_ctrl (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (miss_gnt),
    .fill_i         (fill),
    .tag_i          (tag_q),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .rsp_idx_o      (rsp_idx),
    .rsp_last_o     (rsp_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= L0_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      L0_IDLE: if (miss_gnt) state_d = L0_FILL;
      L0_FILL: if (rsp_last) state_d = L0_DONE;
      L0_DONE: state_d = L0_IDLE;
      default: state_d = L0_IDLE;
    endcase
  end

  // Tag, validity and the registered single-cycle response toward the core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_valid_q <= 1'b0;
      tag_q        <= '0;
      crit_q       <= '0;
      err_seen_q   <= 1'b0;
      flush_seen_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rsp_q        <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if (hit_gnt) begin
        rvalid_q    <= 1'b1;
        rsp_q.rdata <= line_q[req_idx];
        rsp_q.err   <= 1'b0;
      end
      if (miss_gnt) begin
        tag_q        <= req_tag;
        crit_q       <= req_idx;
        line_valid_q <= 1'b0;
        err_seen_q   <= 1'b0;
        flush_seen_q <= 1'b0;
      end else if ((state_q == L0_IDLE) && flush_i) begin
        line_valid_q <= 1'b0;
      end
      if (rsp_we) begin
        err_seen_q <= err_seen_q | instr_err_i;
        if (rsp_idx == crit_q) begin
          rvalid_q    <= 1'b1;
          rsp_q.rdata <= instr_rdata_i;
          rsp_q.err   <= instr_err_i;
        end
      end
      if ((state_q != L0_IDLE) && flush_i) begin
        flush_seen_q <= 1'b1;
      end
      // Commit the line only if every word arrived clean and no flush intervened
      if (state_q == L0_DONE) begin
        line_valid_q <= ~err_seen_q & ~flush_seen_q & ~flush_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LINE_WORDS; i++) begin
        line_q[i] <= '0;
      end
    end else if (rsp_we) begin
      line_q[rsp_idx] <= instr_rdata_i;
    end
  end

  assign core_instr_rvalid_o = rvalid_q;
  assign core_instr_rdata_o  = rsp_q.rdata;
  assign core_instr_err_o    = rsp_q.err;
  assign busy_o              = (state_q != L0_IDLE) | rvalid_q;

`ifdef CV32E40P_L0_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_gnt && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_gnt && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = 32'h0;
  assign miss_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_cv32e40p_instr_l0_buffer.sv
// Scoreboard bench for the L0 instruction buffer: directed scenarios followed by random traffic.
module tb_cv32e40p_instr_l0_buffer;

  localparam int unsigned LW    = 4;
  localparam int unsigned IDX   = 2;
  localparam logic [31:0] LMASK = 32'(LW * 4 - 1);
  localparam logic [31:0] NONE  = 32'hFFFF_FFFF;
  localparam int          INF   = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        core_instr_req_i = 1'b0;
  logic        core_instr_gnt_o;
  logic [31:0] core_instr_addr_i = '0;
  logic        core_instr_rvalid_o;
  logic [31:0] core_instr_rdata_o;
  logic        core_instr_err_o;
  logic        instr_req_o;
  logic        instr_gnt_i = 1'b0;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_err_i = 1'b0;
  logic        busy_o;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  cv32e40p_instr_l0_buffer #(.LINE_WORDS(LW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush_i             (flush_i),
    .core_instr_req_i    (core_instr_req_i),
    .core_instr_gnt_o    (core_instr_gnt_o),
    .core_instr_addr_i   (core_instr_addr_i),
    .core_instr_rvalid_o (core_instr_rvalid_o),
    .core_instr_rdata_o  (core_instr_rdata_o),
    .core_instr_err_o    (core_instr_err_o),
    .instr_req_o         (instr_req_o),
    .instr_gnt_i         (instr_gnt_i),
    .instr_addr_o        (instr_addr_o),
    .instr_rvalid_i      (instr_rvalid_i),
    .instr_rdata_i       (instr_rdata_i),
    .instr_err_i         (instr_err_i),
    .busy_o              (busy_o),
    .hit_cnt_o           (hit_cnt_o),
    .miss_cnt_o          (miss_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; logic err; bit hit; int rcyc; int crit; } exp_rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic err; int rdy; } mem_rsp_t;

  exp_rsp_t    rq[$];
  logic [31:0] aq[$];
  mem_rsp_t    pend[$];

  int passed = 0;
  int total  = 0;

  // Memory and environment knobs
  logic [31:0] salt = '0;
  logic [31:0] err_addr = NONE;
  logic [31:0] stall_addr = NONE;
  int          stall_left = 0;
  int          gnt_pct = 100;
  int          rv_pct = 100;
  int          fill_rsp_cyc[LW];
  int          rsp_k = 0;
  int          mem_gnt_n = 0;
  int          idle_from = 0;
  bit          hold_req = 1'b0;
  logic [31:0] hold_addr = '0;

  // Reference model: one line, identified by its base address
  bit          m_valid = 1'b0;
  logic [31:0] m_base = '0;
  logic [31:0] m_line[LW];
  int          m_hits = 0;
  int          m_misses = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000 ^ salt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory slave: in-order responses, at least one cycle after each grant
  initial begin
    mem_rsp_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
        instr_gnt_i = 1'b0;
        instr_rvalid_i = 1'b0;
        hold_req = 1'b0;
        continue;
      end
      if (hold_req) begin
        chk("mem_req_hold", 32'(instr_req_o), 32'd1);
        chk("mem_addr_hold", instr_addr_o, hold_addr);
      end
      instr_rvalid_i = 1'b0;
      instr_rdata_i = '0;
      instr_err_i = 1'b0;
      if (pend.size() > 0 && pend[0].rdy <= cyc && $urandom_range(99) < 32'(rv_pct)) begin
        r = pend.pop_front();
        instr_rvalid_i = 1'b1;
        instr_rdata_i = r.data;
        instr_err_i = r.err;
        if (rsp_k < LW) fill_rsp_cyc[rsp_k] = cyc;
        rsp_k++;
        if (rsp_k == LW) idle_from = cyc + 2;
      end
      if (stall_left > 0 && instr_req_o && instr_addr_o == stall_addr) begin
        instr_gnt_i = 1'b0;
        stall_left--;
      end else begin
        instr_gnt_i = ($urandom_range(99) < 32'(gnt_pct));
      end
      if (instr_req_o && instr_gnt_i) begin
        if (aq.size() == 0) begin
          total++;
          $display("FAIL mem_req_unexpected: got request to %h want no request", instr_addr_o);
        end else begin
          chk("mem_addr", instr_addr_o, aq.pop_front());
        end
        r.addr = instr_addr_o;
        r.data = mem_word(instr_addr_o);
        r.err = (instr_addr_o == err_addr);
        r.rdy = cyc + 1;
        pend.push_back(r);
        mem_gnt_n++;
      end
      hold_req = instr_req_o && !instr_gnt_i;
      hold_addr = instr_addr_o;
    end
  end

  // Response monitor and slave-side protocol checks
  initial begin
    exp_rsp_t e;
    int want_cyc;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (core_instr_gnt_o) begin
        chk("gnt_only_idle", 32'(cyc >= idle_from), 32'd1);
        chk("single_outstanding", 32'(rq.size()) - 32'(core_instr_rvalid_o), 32'd0);
      end
      if (cyc < idle_from) chk("busy_in_fill", 32'(busy_o), 32'd1);
      if (core_instr_rvalid_o) begin
        if (rq.size() == 0) begin
          total++;
          $display("FAIL rvalid_unexpected: got rvalid data %h want no response", core_instr_rdata_o);
        end else begin
          e = rq.pop_front();
          chk("rdata", core_instr_rdata_o, e.data);
          chk("rerr", 32'(core_instr_err_o), 32'(e.err));
          want_cyc = e.hit ? e.rcyc : fill_rsp_cyc[e.crit] + 1;
          chk("rvalid_cycle", 32'(cyc), 32'(want_cyc));
        end
      end
    end
  end

  // Drive one core request; the model decides hit/miss at the grant edge
  task automatic issue(input logic [31:0] a, input bit fr, input bit fm, input bit exp_imm);
    int waited;
    int gcyc;
    bit hit;
    bit eline;
    logic [31:0] base;
    logic [31:0] wa;
    exp_rsp_t e;
    core_instr_req_i = 1'b1;
    core_instr_addr_i = a;
    waited = 0;
    forever begin
      @(negedge clk);
      if (core_instr_gnt_o) break;
      waited++;
      if (waited > 400) begin
        total++;
        $display("FAIL gnt_timeout: got no grant for %h want grant within 400 cycles", a);
        core_instr_req_i = 1'b0;
        return;
      end
    end
    gcyc = cyc;
    if (fr) flush_i = 1'b1;
    if (exp_imm) chk("gnt_same_cycle", 32'(waited), 32'd0);
    base = a & ~LMASK;
    hit = m_valid && (base == m_base) && !fr;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    core_instr_req_i = 1'b0;
    if (hit) begin
      m_hits++;
      e.data = m_line[int'(a[IDX+1:2])];
      e.err = 1'b0;
      e.hit = 1'b1;
      e.rcyc = gcyc + 1;
      e.crit = 0;
      rq.push_back(e);
    end else begin
      m_misses++;
      eline = 1'b0;
      for (int i = 0; i < LW; i++) begin
        wa = base + 32'(4 * i);
        aq.push_back(wa);
        m_line[i] = mem_word(wa);
        if (wa == err_addr) eline = 1'b1;
        fill_rsp_cyc[i] = INF;
      end
      e.data = mem_word(a);
      e.err = (a == err_addr);
      e.hit = 1'b0;
      e.rcyc = 0;
      e.crit = int'(a[IDX+1:2]);
      m_valid = !eline && !fm;
      m_base = base;
      rsp_k = 0;
      mem_gnt_n = 0;
      idle_from = INF;
      rq.push_back(e);
      if (fm) begin
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
      end
    end
  endtask

  task automatic idle_flush();
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy_o && rq.size() == 0 && aq.size() == 0 && pend.size() == 0) break;
      n++;
      if (n > 500) begin
        total++;
        $display("FAIL idle_timeout: got busy %0d rq %0d aq %0d want all drained", busy_o, rq.size(), aq.size());
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters();
`ifdef CV32E40P_L0_PERF_EN
    chk("hit_cnt", hit_cnt_o, 32'(m_hits));
    chk("miss_cnt", miss_cnt_o, 32'(m_misses));
`else
    chk("hit_cnt", hit_cnt_o, 32'd0);
    chk("miss_cnt", miss_cnt_o, 32'd0);
`endif
  endtask

  task automatic chk_reset_outputs();
    chk("rst_gnt", 32'(core_instr_gnt_o), 32'd0);
    chk("rst_rvalid", 32'(core_instr_rvalid_o), 32'd0);
    chk("rst_rdata", core_instr_rdata_o, 32'd0);
    chk("rst_err", 32'(core_instr_err_o), 32'd0);
    chk("rst_req", 32'(instr_req_o), 32'd0);
    chk("rst_addr", instr_addr_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_hit_cnt", hit_cnt_o, 32'd0);
    chk("rst_miss_cnt", miss_cnt_o, 32'd0);
  endtask

  initial begin
    logic [31:0] pool[3];
    logic [31:0] a;
    int op;
    int n;
    pool[0] = 32'h0000_1000;
    pool[1] = 32'h0000_2000;
    pool[2] = 32'h0000_1010;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Cold miss with the critical word in the middle of the line
    issue(32'h0000_0108, 1'b0, 1'b0, 1'b1);
    wait_idle();
    chk_counters();

    // Back-to-back hits at one per cycle
    issue(32'h0000_0100, 1'b0, 1'b0, 1'b1);
    issue(32'h0000_0104, 1'b0, 1'b0, 1'b1);
    issue(32'h0000_010C, 1'b0, 1'b0, 1'b1);
    wait_idle();
    chk_counters();

    // Flush together with a request, then flush during a fill
    issue(32'h0000_0104, 1'b1, 1'b0, 1'b1);
    wait_idle();
    issue(32'h0000_0300, 1'b0, 1'b1, 1'b1);
    wait_idle();
    issue(32'h0000_0300, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Error on a non-critical word, then on the critical word
    err_addr = 32'h0000_0208;
    issue(32'h0000_0204, 1'b0, 1'b0, 1'b1);
    wait_idle();
    issue(32'h0000_0204, 1'b0, 1'b0, 1'b1);
    wait_idle();
    err_addr = 32'h0000_0204;
    issue(32'h0000_0204, 1'b0, 1'b0, 1'b1);
    wait_idle();
    err_addr = NONE;

    // Memory grant stall on the second word with a core request pending
    idle_flush();
    stall_addr = 32'h0000_0104;
    stall_left = 3;
    issue(32'h0000_0100, 1'b0, 1'b0, 1'b1);
    issue(32'h0000_0500, 1'b0, 1'b0, 1'b0);
    wait_idle();
    chk("stall_consumed", 32'(stall_left), 32'd0);
    stall_addr = NONE;
    chk_counters();

    // Reset in the middle of a fill
    idle_flush();
    issue(32'h0000_010C, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (mem_gnt_n < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    rq.delete();
    aq.delete();
    pend.delete();
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0;
    hold_req = 1'b0;
    idle_from = 0;
    m_valid = 1'b0;
    m_hits = 0;
    m_misses = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(32'h0000_010C, 1'b0, 1'b0, 1'b1);
    wait_idle();
    chk_counters();

    // Random traffic over three lines with random memory timing
    gnt_pct = 70;
    rv_pct = 70;
    for (int it = 0; it < 250; it++) begin
      op = int'($urandom_range(99));
      if (op < 5) begin
        wait_idle();
        err_addr = ($urandom_range(2) == 0) ?
                   pool[$urandom_range(2)] + 32'(4 * $urandom_range(LW - 1)) : NONE;
        salt = $urandom;
        idle_flush();
      end else if (op < 10) begin
        idle_flush();
      end else begin
        a = pool[$urandom_range(2)] + 32'(4 * $urandom_range(LW - 1));
        issue(a, ($urandom_range(9) == 0), ($urandom_range(6) == 0), 1'b0);
      end
    end
    wait_idle();
    chk_counters();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
